// File: rtl/axis2grid_pkg.sv
// Shared types for the stream-to-grid receiver.
// The state encoding is fixed so that other blocks and debug tools read the same values.
package axis2grid_pkg;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/axis2grid.sv
// AXI4-Stream slave that collects one frame of pixels, one per beat in row-major order,
// reduces each pixel to an alive bit and publishes the packed grid over valid/ready.
module axis2grid
  import axis2grid_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DWIDTH-1:0]          alive_color,
  input  logic [DWIDTH-1:0]          S_AXIS_TDATA,
  input  logic                       S_AXIS_TVALID,
  output logic                       S_AXIS_TREADY,
  input  logic                       S_AXIS_TLAST,
  output logic [WIDTH*HEIGHT-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       frame_err,
  output logic [15:0]                err_count
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [NPIX-1:0]   r_data;
  logic              r_err;
  logic [15:0]       r_errcnt;
  logic              r_drain;

  logic w_beat, w_last_pix, w_alive;

  assign S_AXIS_TREADY = rstn && (r_state != HOLD);
  assign w_beat        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_last_pix    = (r_cnt == CW'(NPIX - 1));
  assign w_alive       = (S_AXIS_TDATA == alive_color);

  assign out_data  = r_data;
  assign out_valid = (r_state == HOLD);
  assign frame_err = r_err;
  assign err_count = r_errcnt;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= RECV;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RECV:    if (w_beat && w_last_pix) w_next = HOLD;
      HOLD:    if (out_ready) w_next = r_drain ? DRAIN : RECV;
      DRAIN:   if (w_beat && S_AXIS_TLAST) w_next = RECV;
      default: w_next = RECV;
    endcase
  end

  // Datapath: pixel store, counter, framing error tracking.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_errcnt <= '0;
      r_drain  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        RECV: begin
          if (w_beat) begin
            if (!w_last_pix && S_AXIS_TLAST) begin
              // Early TLAST: drop the partial frame, restart at pixel 0.
              r_cnt <= '0;
              r_err <= 1'b1;
              if (r_errcnt != 16'hFFFF) r_errcnt <= r_errcnt + 16'd1;
            end else begin
              r_data[r_cnt] <= w_alive;
              if (w_last_pix) begin
                r_cnt <= '0;
                if (!S_AXIS_TLAST) begin
                  // Frame is still published; the stray tail is drained afterwards.
                  r_err   <= 1'b1;
                  r_drain <= 1'b1;
                  if (r_errcnt != 16'hFFFF) r_errcnt <= r_errcnt + 16'd1;
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
        end
        HOLD:    if (out_ready) r_drain <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis2grid.sv
// Directed bench for axis2grid with a frame-level reference model checked every cycle.
module tb_axis2grid;

  localparam int NPIX = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] alive_color = 32'h00FF_FFFF;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tlast = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        frame_err;
  logic [15:0] err_count;

  logic [31:0] dead_val = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  axis2grid #(.DWIDTH(32), .WIDTH(4), .HEIGHT(4)) dut (
    .clk(clk), .rstn(rstn), .alive_color(alive_color),
    .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .S_AXIS_TLAST(tlast), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: pixels of the frame in progress kept as a queue; a frame is
  // published when NPIX pixels have arrived, dropped on a premature TLAST.
  bit        q[$];
  bit        m_hold = 0;
  bit        m_draining = 0;
  bit        m_drain_pend = 0;
  bit        m_err = 0;
  int        m_errcnt = 0;
  logic [15:0] m_data = '0;

  always @(negedge clk) begin
    if (started) begin
      chk("tready",    {31'd0, tready},    {31'd0, rstn && !m_hold});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
      chk("err_count", {16'd0, err_count}, m_errcnt);
      if (m_hold) chk("out_data", {16'd0, out_data}, {16'd0, m_data});
    end
    // advance the model by the edge that is about to happen
    if (!rstn) begin
      q.delete();
      m_hold = 0; m_draining = 0; m_drain_pend = 0; m_err = 0; m_errcnt = 0;
    end else begin
      m_err = 0;
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 0;
          m_draining = m_drain_pend;
          m_drain_pend = 0;
        end
      end else if (m_draining) begin
        if (tvalid && tlast) m_draining = 0;
      end else if (tvalid) begin
        q.push_back(tdata == alive_color);
        if (q.size() == NPIX) begin
          for (int k = 0; k < NPIX; k++) m_data[k] = q[k];
          q.delete();
          m_hold = 1;
          if (!tlast) begin
            m_err = 1; m_drain_pend = 1;
            if (m_errcnt < 65535) m_errcnt++;
          end
        end else if (tlast) begin
          q.delete();
          m_err = 1;
          if (m_errcnt < 65535) m_errcnt++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    logic ok;
    tdata = d; tlast = l; tvalid = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk); ok = tready;
      @(posedge clk); #1;
      if (ok) break;
      if (i > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got no TREADY, expected TREADY within 200 cycles");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0; tlast = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [15:0] pat, input bit with_last, input bit gaps);
    for (int k = 0; k < NPIX; k++) begin
      send(pat[k] ? alive_color : dead_val, with_last && (k == NPIX - 1));
      if (gaps && k != NPIX - 1) idle($urandom_range(0, 2));
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    tvalid = 1'b0;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with TVALID asserted
    tvalid = 1'b1; tdata = 32'h00FF_FFFF;
    @(posedge clk); started = 1; #1;
    @(negedge clk);
    chk("rst_tready",  {31'd0, tready}, 0);
    chk("rst_valid",   {31'd0, out_valid}, 0);
    chk("rst_errcnt",  {16'd0, err_count}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tvalid = 1'b0; rstn = 1'b1;
    @(negedge clk);
    chk("tready_after_rst", {31'd0, tready}, 1);
    @(posedge clk); #1;

    // 2. nominal alternating frame, back-to-back
    out_ready = 1'b1;
    send_frame(16'h5555, 1, 0);
    @(negedge clk);
    chk("nom_valid",  {31'd0, out_valid}, 1);
    chk("nom_data",   {16'd0, out_data}, 32'h5555);
    chk("nom_tready", {31'd0, tready}, 0);
    chk("nom_model",  {16'd0, m_data}, 32'h5555);
    @(negedge clk);
    chk("nom_tready_back", {31'd0, tready}, 1);
    chk("nom_valid_low",   {31'd0, out_valid}, 0);
    @(posedge clk); #1;

    // 3. all-alive with gaps, held under backpressure
    out_ready = 1'b0;
    send_frame(16'hFFFF, 1, 1);
    tvalid = 1'b1; tdata = dead_val; tlast = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_data",   {16'd0, out_data}, 32'hFFFF);
      chk("bp_tready", {31'd0, tready}, 0);
      chk("bp_valid",  {31'd0, out_valid}, 1);
    end
    @(posedge clk); #1;
    tvalid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 1);
    @(negedge clk);
    chk("bp_after_valid",  {31'd0, out_valid}, 0);
    chk("bp_after_tready", {31'd0, tready}, 1);
    @(posedge clk); #1;

    // 4. early TLAST on beat 10, then pixel-0-only frame
    for (int k = 0; k < 10; k++) send(alive_color, k == 9);
    idle(0);
    @(negedge clk);
    chk("early_err",    {31'd0, frame_err}, 1);
    chk("early_cnt",    {16'd0, err_count}, 1);
    chk("early_valid",  {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("early_err_pulse", {31'd0, frame_err}, 0);
    @(posedge clk); #1;
    send_frame(16'h0001, 1, 0);
    @(negedge clk);
    chk("early_next_data", {16'd0, out_data}, 32'h0001);
    chk("early_next_valid", {31'd0, out_valid}, 1);
    @(posedge clk); #1;

    // 5. missing TLAST, then a 3-beat tail that must be drained
    do_reset(2);
    out_ready = 1'b0;
    send_frame(16'h1234, 0, 0);
    @(negedge clk);
    chk("miss_valid", {31'd0, out_valid}, 1);
    chk("miss_data",  {16'd0, out_data}, 32'h1234);
    chk("miss_err",   {31'd0, frame_err}, 1);
    chk("miss_cnt",   {16'd0, err_count}, 1);
    chk("miss_model", {16'd0, m_data}, 32'h1234);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(alive_color, 0);
    send(alive_color, 0);
    send(alive_color, 1);
    idle(0);
    repeat (3) begin
      @(negedge clk);
      chk("drain_valid", {31'd0, out_valid}, 0);
      chk("drain_err",   {31'd0, frame_err}, 0);
    end
    chk("drain_cnt", {16'd0, err_count}, 1);
    @(posedge clk); #1;
    send_frame(16'hBEEF, 1, 1);
    @(negedge clk);
    chk("post_drain_data", {16'd0, out_data}, 32'hBEEF);
    @(posedge clk); #1;

    // 6. reset mid-frame
    for (int k = 0; k < 7; k++) send(alive_color, 0);
    do_reset(2);
    send_frame(16'hA5C3, 1, 0);
    @(negedge clk);
    chk("midrst_data", {16'd0, out_data}, 32'hA5C3);
    chk("midrst_cnt",  {16'd0, err_count}, 0);
    @(posedge clk); #1;

    // 7. new alive colour; old alive colour and a one-bit near miss are both dead
    alive_color = 32'hDEAD_BEEF;
    dead_val    = 32'h00FF_FFFF;
    send_frame(16'h00FF, 1, 0);
    @(negedge clk);
    chk("color_data", {16'd0, out_data}, 32'h00FF);
    @(posedge clk); #1;
    dead_val = 32'h5EAD_BEEF;
    send_frame(16'hF00F, 1, 0);
    @(negedge clk);
    chk("nearmiss_data", {16'd0, out_data}, 32'hF00F);
    @(posedge clk); #1;

    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
